// File: rtl/output_image_streamer.sv
// Streams a finished image from memory as a row-major pixel stream with eol/eof markers.
// Define STREAMER_BORDER_CLEAR_EN to force the outermost rows and columns of the output to zero.
module output_image_streamer #(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned ADDR_WIDTH        = 16,
  parameter int unsigned IMAGE_ROW_SIZE    = 64,
  parameter int unsigned IMAGE_COLUMN_SIZE = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  output logic                  mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_eol_o,
  output logic                  m_eof_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned NUM_PIX = IMAGE_ROW_SIZE * IMAGE_COLUMN_SIZE;
  localparam int unsigned COL_W   = (IMAGE_COLUMN_SIZE > 1) ? $clog2(IMAGE_COLUMN_SIZE) : 1;
  localparam int unsigned ROW_W   = (IMAGE_ROW_SIZE > 1) ? $clog2(IMAGE_ROW_SIZE) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIX - 1);
  localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(IMAGE_COLUMN_SIZE - 1);
  localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(IMAGE_ROW_SIZE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_start_q;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [COL_W-1:0]      r_col;
  logic [ROW_W-1:0]      r_row;
  logic                  r_pend;
  logic [COL_W-1:0]      r_pend_col;
  logic [ROW_W-1:0]      r_pend_row;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_eol;
  logic                  r_eof;
  logic                  r_buf_valid;
  logic [DATA_WIDTH-1:0] r_buf_data;
  logic                  r_buf_eol;
  logic                  r_buf_eof;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_start_edge;
  logic                  w_pop;
  logic                  w_eof_hs;
  logic [1:0]            w_occ;
  logic                  w_credit_ok;
  logic                  w_rd_en;
  logic [DATA_WIDTH-1:0] w_push_data;
  logic                  w_push_eol;
  logic                  w_push_eof;

  assign w_start_edge = start_i & ~r_start_q;
  assign w_pop        = r_valid & m_ready_i;
  assign w_eof_hs     = w_pop & r_eof;

  // Buffered pixels plus the read whose data is on the bus; a slot freed by this cycle's pop
  // can be reused so the stream keeps one pixel per cycle without overflowing the 2-entry FIFO.
  assign w_occ       = 2'(r_valid) + 2'(r_buf_valid) + 2'(r_pend);
  assign w_credit_ok = (w_occ - 2'(w_pop)) < 2'd2;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_start_q <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_start_q <= start_i;
      r_busy    <= (w_state_next != ST_IDLE);
      r_done    <= w_eof_hs;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_edge) w_state_next = ST_STREAM;
      end
      ST_STREAM: begin
        w_rd_en = w_credit_ok;
        if (w_credit_ok && (r_addr == LAST_ADDR)) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_eof_hs) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Read address with matching row/column counters; holds at the last pixel, rewinds on start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr     <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_pend     <= 1'b0;
      r_pend_col <= '0;
      r_pend_row <= '0;
    end else begin
      r_pend <= w_rd_en;
      if (w_rd_en) begin
        r_pend_col <= r_col;
        r_pend_row <= r_row;
      end
      if ((r_state == ST_IDLE) && w_start_edge) begin
        r_addr <= '0;
        r_col  <= '0;
        r_row  <= '0;
      end else if (w_rd_en && (r_addr != LAST_ADDR)) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
        if (r_col == LAST_COL) begin
          r_col <= '0;
          r_row <= r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
    end
  end

  assign w_push_eol = (r_pend_col == LAST_COL);
  assign w_push_eof = w_push_eol && (r_pend_row == LAST_ROW);

`ifdef STREAMER_BORDER_CLEAR_EN
  always_comb begin
    w_push_data = mem_data_i;
    if ((r_pend_row == '0) || (r_pend_row == LAST_ROW) ||
        (r_pend_col == '0) || (r_pend_col == LAST_COL)) begin
      w_push_data = '0;
    end
  end
`else
  assign w_push_data = mem_data_i;
`endif

  // Two-entry FIFO: head drives the stream outputs directly, second entry absorbs backpressure.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_eol       <= 1'b0;
      r_eof       <= 1'b0;
      r_buf_valid <= 1'b0;
      r_buf_data  <= '0;
      r_buf_eol   <= 1'b0;
      r_buf_eof   <= 1'b0;
    end else if (!r_valid || w_pop) begin
      if (r_buf_valid) begin
        r_valid     <= 1'b1;
        r_data      <= r_buf_data;
        r_eol       <= r_buf_eol;
        r_eof       <= r_buf_eof;
        r_buf_valid <= r_pend;
        if (r_pend) begin
          r_buf_data <= w_push_data;
          r_buf_eol  <= w_push_eol;
          r_buf_eof  <= w_push_eof;
        end
      end else begin
        r_valid <= r_pend;
        if (r_pend) begin
          r_data <= w_push_data;
          r_eol  <= w_push_eol;
          r_eof  <= w_push_eof;
        end
      end
    end else if (r_pend) begin
      r_buf_valid <= 1'b1;
      r_buf_data  <= w_push_data;
      r_buf_eol   <= w_push_eol;
      r_buf_eof   <= w_push_eof;
    end
  end

  assign mem_rd_en_o = w_rd_en;
  assign mem_addr_o  = r_addr;
  assign m_valid_o   = r_valid;
  assign m_data_o    = r_data;
  assign m_eol_o     = r_eol;
  assign m_eof_o     = r_eof;
  assign busy_o      = r_busy;
  assign done_o      = r_done;

endmodule

// File: tb/tb_output_image_streamer.sv
// Scoreboard bench for output_image_streamer on a 4x4 image with memory data = address.
module tb_output_image_streamer;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 16;
  localparam int          R  = 4;
  localparam int          C  = 4;
  localparam int          N  = R * C;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          eol;
    logic          eof;
  } pix_t;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic          mem_rd_en_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_i = '0;
  logic          m_valid_o;
  logic          m_ready_i = 1'b0;
  logic [DW-1:0] m_data_o;
  logic          m_eol_o;
  logic          m_eof_o;
  logic          busy_o;
  logic          done_o;

  output_image_streamer #(
    .DATA_WIDTH       (DW),
    .ADDR_WIDTH       (AW),
    .IMAGE_ROW_SIZE   (R),
    .IMAGE_COLUMN_SIZE(C)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .mem_rd_en_o(mem_rd_en_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_i (mem_data_i),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .m_data_o   (m_data_o),
    .m_eol_o    (m_eol_o),
    .m_eof_o    (m_eof_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Memory returns data = address one cycle after the strobe, noise otherwise.
  always @(posedge clk_i) mem_data_i <= mem_rd_en_o ? DW'(mem_addr_o) : DW'($urandom);

  int   checks = 0;
  int   failures = 0;
  pix_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic pix_t ref_pix(input int i);
    pix_t p;
    int   row = i / C;
    int   col = i % C;
    p.d   = DW'(i);
`ifdef STREAMER_BORDER_CLEAR_EN
    if (row == 0 || row == R - 1 || col == 0 || col == C - 1) p.d = '0;
`endif
    p.eol = (col == C - 1);
    p.eof = (i == N - 1);
    return p;
  endfunction

  // Monitor state
  int            exp_addr = 0;
  int            outst = 0;
  int            n_xfer = 0;
  int            n_reads = 0;
  int            act_start = -1;
  int            first_valid_cyc = -1;
  int            first_rd_cyc = -1;
  int            eof_cyc = -1;
  int            done_cnt = 0;
  bit            exp_busy = 0;
  bit            exp_done = 0;
  bit            prev_hold = 0;
  bit            prev_rd = 0;
  logic [AW-1:0] prev_addr = '0;
  pix_t          prev_pix;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      exp_q.delete();
      exp_addr = 0; outst = 0; act_start = -1;
      exp_busy = 0; exp_done = 0; prev_hold = 0; prev_rd = 0; prev_addr = '0;
    end else begin
      pix_t e;
      bit   pop;
      pop = m_valid_o && m_ready_i;
      if (cyc == act_start) exp_busy = 1;
      check("busy", 32'(busy_o), 32'(exp_busy));
      check("done", 32'(done_o), 32'(exp_done));
      if (done_o) done_cnt++;
      exp_done = 0;
      if (mem_rd_en_o) begin
        check("rd_addr", 32'(mem_addr_o), 32'(exp_addr));
        check("outstanding_le2", 32'((outst + 1 - (pop ? 1 : 0)) <= 2), 32'd1);
        if (n_reads == 0) first_rd_cyc = cyc;
        exp_addr++;
        n_reads++;
      end else if (!prev_rd) begin
        check("addr_hold", 32'(mem_addr_o), 32'(prev_addr));
      end
      if (prev_hold) begin
        check("hold_valid", 32'(m_valid_o), 32'd1);
        check("hold_data", 32'({m_data_o, m_eol_o, m_eof_o}), 32'(prev_pix));
      end
      if (m_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (pop) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_pixel at cycle %0d: got %0d expected none", cyc, m_data_o);
        end else begin
          e = exp_q.pop_front();
          check("pix_data", 32'(m_data_o), 32'(e.d));
          check("pix_eol", 32'(m_eol_o), 32'(e.eol));
          check("pix_eof", 32'(m_eof_o), 32'(e.eof));
        end
        n_xfer++;
        if (m_eof_o) begin
          exp_done = 1; exp_busy = 0; exp_addr = 0; eof_cyc = cyc;
        end
      end
      outst     = outst + (mem_rd_en_o ? 1 : 0) - (pop ? 1 : 0);
      prev_hold = m_valid_o && !m_ready_i;
      prev_pix  = {m_data_o, m_eol_o, m_eof_o};
      prev_rd   = mem_rd_en_o;
      prev_addr = mem_addr_o;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"}, 32'(mem_rd_en_o), 32'd0);
    check({tag, "_addr"},  32'(mem_addr_o),  32'd0);
    check({tag, "_valid"}, 32'(m_valid_o),   32'd0);
    check({tag, "_data"},  32'(m_data_o),    32'd0);
    check({tag, "_eol"},   32'(m_eol_o),     32'd0);
    check({tag, "_eof"},   32'(m_eof_o),     32'd0);
    check({tag, "_busy"},  32'(busy_o),      32'd0);
    check({tag, "_done"},  32'(done_o),      32'd0);
  endtask

  int start_cyc = 0;

  task automatic start_frame();
    n_xfer = 0; n_reads = 0; first_valid_cyc = -1; first_rd_cyc = -1; eof_cyc = -1; done_cnt = 0;
    for (int i = 0; i < N; i++) exp_q.push_back(ref_pix(i));
    start_cyc = cyc;
    act_start = cyc + 1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // mode 0: ready high, 1: ready 1010.., 2: stall 20 cycles after first valid,
  // 3: random ready, 4: ready high with a second start at pixel 5
  task automatic run_frame(input int mode);
    bit sent = 0;
    bit bp_checked = 0;
    m_ready_i = (mode == 2) ? 1'b0 : 1'b1;
    start_frame();
    for (int k = 0; k < 400 && done_cnt == 0; k++) begin
      start_i = 1'b0;
      case (mode)
        1: m_ready_i = ~m_ready_i;
        2: begin
          if (first_valid_cyc >= 0 && cyc == first_valid_cyc + 20 && !bp_checked) begin
            bp_checked = 1;
            check("bp_reads", 32'(n_reads), 32'd2);
            check("bp_data", 32'(m_data_o), 32'(ref_pix(0).d));
            check("bp_valid", 32'(m_valid_o), 32'd1);
          end
          m_ready_i = (first_valid_cyc >= 0 && cyc >= first_valid_cyc + 20) ? 1'b1 : 1'b0;
        end
        3: m_ready_i = 1'($urandom_range(0, 1));
        4: begin
          m_ready_i = 1'b1;
          if (n_xfer == 5 && !sent) begin
            start_i = 1'b1;
            sent = 1;
          end
        end
        default: m_ready_i = 1'b1;
      endcase
      tick();
    end
    start_i = 1'b0;
    if (done_cnt == 0) begin
      checks++; failures++;
      $display("FAIL frame_timeout mode %0d: got %0d pixels expected %0d", mode, n_xfer, N);
    end
    m_ready_i = 1'b1;
    repeat (6) tick();
    check("done_single", 32'(done_cnt), 32'd1);
    check("pixel_count", 32'(n_xfer), 32'(N));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("idle_busy", 32'(busy_o), 32'd0);
    check("idle_valid", 32'(m_valid_o), 32'd0);
    if (mode == 2) check("bp_checked", 32'(bp_checked), 32'd1);
    if (mode == 0) begin
      check("first_read_lat", 32'(first_rd_cyc - start_cyc), 32'd1);
      check("first_valid_lat", 32'(first_valid_cyc - start_cyc), 32'd3);
      check("full_rate", 32'(eof_cyc - first_valid_cyc), 32'(N - 1));
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    repeat (3) tick();
    check_outputs_zero("reset");
    rst_ni = 1'b1;
    repeat (2) tick();

    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(4);
    run_frame(3);
    run_frame(3);

    // Reset in the middle of a frame aborts it without a completion pulse.
    m_ready_i = 1'b1;
    start_frame();
    for (int k = 0; k < 200 && n_xfer < 8; k++) tick();
    check("abort_reached_px8", 32'(n_xfer), 32'd8);
    done_cnt = 0;
    rst_ni = 1'b0;
    #1;
    check_outputs_zero("abort");
    repeat (3) tick();
    rst_ni = 1'b1;
    repeat (3) tick();
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_frame(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
